// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register with stall/flush, sub-word load extraction,
// a registered write-back mux and a retired-instruction counter.
module mem_wb_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int INSTR_W    = 32,
  parameter int CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic                  mem_stall,
  input  logic                  mem_flush,
  input  logic [INSTR_W-1:0]    mem_instruction,
  input  logic                  mem_shouldWriteRegister,
  input  logic [REG_ADDR_W-1:0] mem_registerWriteAddress,
  input  logic                  mem_shouldWriteMemoryElseAluOutputToRegister,
  input  logic [1:0]            mem_loadSize,
  input  logic                  mem_loadUnsigned,
  input  logic [DATA_W-1:0]     mem_memoryData,
  input  logic [DATA_W-1:0]     mem_aluOutput,
  output logic                  wb_valid,
  output logic [INSTR_W-1:0]    wb_instruction,
  output logic                  wb_shouldWriteRegister,
  output logic [REG_ADDR_W-1:0] wb_registerWriteAddress,
  output logic [DATA_W-1:0]     wb_writeData,
  output logic                  wb_misaligned,
  output logic [CNT_W-1:0]      wb_retireCount
);

  localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] sh_b;
  logic [DATA_W-1:0] sh_h;
  logic [DATA_W-1:0] sh_w;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] wdata;
  logic              load_sel;
  logic              is_dbl;
  logic              word_hi;
  logic              mis_raw;
  logic              mis;
  logic              we;

  assign off      = mem_aluOutput[OFF_W-1:0];
  assign load_sel = mem_shouldWriteMemoryElseAluOutputToRegister;
  assign is_dbl   = (DATA_W == 64) && (mem_loadSize == 2'b11);
  assign word_hi  = (DATA_W == 64) && off[OFF_W-1];

  // Lane selection as right shifts so every width stays in range.
  assign sh_b = mem_memoryData >> {off, 3'b000};
  assign sh_h = mem_memoryData >> {off[OFF_W-1:1], 4'b0000};
  assign sh_w = mem_memoryData >> {word_hi, 5'b00000};

  always_comb begin
    load_data = mem_memoryData;
    mis_raw   = 1'b0;
    unique case (1'b1)
      mem_loadSize == 2'b00: begin
        load_data = mem_loadUnsigned ? DATA_W'(sh_b[7:0])
                                     : DATA_W'($signed(sh_b[7:0]));
      end
      mem_loadSize == 2'b01: begin
        load_data = mem_loadUnsigned ? DATA_W'(sh_h[15:0])
                                     : DATA_W'($signed(sh_h[15:0]));
        mis_raw   = off[0];
      end
      is_dbl: begin
        load_data = mem_memoryData;
        mis_raw   = (off != '0);
      end
      default: begin
        load_data = mem_loadUnsigned ? DATA_W'(sh_w[31:0])
                                     : DATA_W'($signed(sh_w[31:0]));
        mis_raw   = (off[1:0] != 2'b00);
      end
    endcase
  end

  assign mis   = load_sel & mis_raw;
  assign wdata = load_sel ? load_data : mem_aluOutput;
  assign we    = mem_valid & mem_shouldWriteRegister
               & (mem_registerWriteAddress != '0) & ~mis;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid                <= 1'b0;
      wb_instruction          <= '0;
      wb_shouldWriteRegister  <= 1'b0;
      wb_registerWriteAddress <= '0;
      wb_writeData            <= '0;
      wb_misaligned           <= 1'b0;
      wb_retireCount          <= '0;
    end else if (mem_flush) begin
      wb_valid                <= 1'b0;
      wb_instruction          <= '0;
      wb_shouldWriteRegister  <= 1'b0;
      wb_registerWriteAddress <= '0;
      wb_writeData            <= '0;
      wb_misaligned           <= 1'b0;
    end else if (!mem_stall) begin
      wb_valid                <= mem_valid;
      wb_instruction          <= mem_instruction;
      wb_shouldWriteRegister  <= we;
      wb_registerWriteAddress <= mem_registerWriteAddress;
      wb_writeData            <= wdata;
      wb_misaligned           <= mem_valid & mis;
      if (mem_valid)
        wb_retireCount <= wb_retireCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Bench for mem_wb_stage_reg: 32-bit and 64-bit instances driven together
// and compared against a byte-lane reference model.
module tb_mem_wb_stage_reg;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        mem_stall;
  logic        mem_flush;
  logic [31:0] instr;
  logic        swr;
  logic [4:0]  addr;
  logic        sel;
  logic [1:0]  size;
  logic        uns;
  logic [63:0] mdata;
  logic [63:0] alu;

  logic        v32, we32, m32, v64, we64, m64;
  logic [31:0] i32, i64;
  logic [4:0]  a32, a64;
  logic [31:0] d32;
  logic [63:0] d64;
  logic [3:0]  c32;
  logic [7:0]  c64;

  logic        e_v[2], e_we[2], e_m[2];
  logic [31:0] e_i[2];
  logic [4:0]  e_a[2];
  logic [63:0] e_d[2];
  int          e_c[2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_wb_stage_reg #(.DATA_W(32), .CNT_W(4)) u32 (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_stall(mem_stall), .mem_flush(mem_flush),
    .mem_instruction(instr), .mem_shouldWriteRegister(swr),
    .mem_registerWriteAddress(addr),
    .mem_shouldWriteMemoryElseAluOutputToRegister(sel),
    .mem_loadSize(size), .mem_loadUnsigned(uns),
    .mem_memoryData(mdata[31:0]), .mem_aluOutput(alu[31:0]),
    .wb_valid(v32), .wb_instruction(i32),
    .wb_shouldWriteRegister(we32), .wb_registerWriteAddress(a32),
    .wb_writeData(d32), .wb_misaligned(m32), .wb_retireCount(c32)
  );

  mem_wb_stage_reg #(.DATA_W(64), .CNT_W(8)) u64 (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_stall(mem_stall), .mem_flush(mem_flush),
    .mem_instruction(instr), .mem_shouldWriteRegister(swr),
    .mem_registerWriteAddress(addr),
    .mem_shouldWriteMemoryElseAluOutputToRegister(sel),
    .mem_loadSize(size), .mem_loadUnsigned(uns),
    .mem_memoryData(mdata), .mem_aluOutput(alu),
    .wb_valid(v64), .wb_instruction(i64),
    .wb_shouldWriteRegister(we64), .wb_registerWriteAddress(a64),
    .wb_writeData(d64), .wb_misaligned(m64), .wb_retireCount(c64)
  );

  // Returns {misaligned, writeData} for a datapath of w bits.
  function automatic logic [64:0] calc(int w);
    int nb, off, start;
    logic [63:0] mem, a, mask, v;
    mem = (w == 64) ? mdata : {32'b0, mdata[31:0]};
    a   = (w == 64) ? alu : {32'b0, alu[31:0]};
    off = int'(a[2:0]) % (w / 8);
    case (size)
      2'b00:   nb = 1;
      2'b01:   nb = 2;
      2'b10:   nb = 4;
      default: nb = (w == 64) ? 8 : 4;
    endcase
    start = (off / nb) * nb;
    mask  = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    v     = (mem >> (8 * start)) & mask;
    if (!uns && v[8 * nb - 1]) v = v | ~mask;
    if (w == 32) v[63:32] = '0;
    if (!sel) v = a;
    return {sel && (off % nb != 0), v};
  endfunction

  task automatic model_clear(input bit keep_cnt);
    for (int k = 0; k < 2; k++) begin
      e_v[k] = 0; e_we[k] = 0; e_m[k] = 0;
      e_i[k] = '0; e_a[k] = '0; e_d[k] = '0;
      if (!keep_cnt) e_c[k] = 0;
    end
  endtask

  task automatic model_edge();
    logic [64:0] r;
    if (mem_flush) model_clear(1'b1);
    else if (!mem_stall) begin
      for (int k = 0; k < 2; k++) begin
        r = calc(k == 0 ? 32 : 64);
        e_v[k]  = mem_valid;
        e_i[k]  = instr;
        e_a[k]  = addr;
        e_d[k]  = r[63:0];
        e_m[k]  = mem_valid & r[64];
        e_we[k] = mem_valid & swr & (addr != 5'd0) & ~r[64];
        if (mem_valid) e_c[k] = (e_c[k] + 1) % (k == 0 ? 16 : 256);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("v32", 64'(v32), 64'(e_v[0]));
    chk("i32", 64'(i32), 64'(e_i[0]));
    chk("we32", 64'(we32), 64'(e_we[0]));
    chk("a32", 64'(a32), 64'(e_a[0]));
    chk("d32", 64'(d32), e_d[0]);
    chk("m32", 64'(m32), 64'(e_m[0]));
    chk("c32", 64'(c32), 64'(e_c[0]));
    chk("v64", 64'(v64), 64'(e_v[1]));
    chk("i64", 64'(i64), 64'(e_i[1]));
    chk("we64", 64'(we64), 64'(e_we[1]));
    chk("a64", 64'(a64), 64'(e_a[1]));
    chk("d64", d64, e_d[1]);
    chk("m64", 64'(m64), 64'(e_m[1]));
    chk("c64", 64'(c64), 64'(e_c[1]));
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_in();
    mem_valid = ($urandom_range(0, 3) != 0);
    mem_stall = 1'b0;
    mem_flush = 1'b0;
    instr     = $urandom;
    swr       = 1'($urandom);
    addr      = 5'($urandom);
    sel       = 1'($urandom);
    size      = 2'($urandom);
    uns       = 1'($urandom);
    mdata     = {$urandom, $urandom};
    alu       = {$urandom, $urandom};
  endtask

  initial begin
    reset = 1'b1;
    rand_in();
    model_clear(1'b0);
    repeat (3) begin
      rand_in();
      @(posedge clock);
      #1;
      check_all();
    end
    reset     = 1'b0;
    mem_valid = 1'b1;
    tick();
    chk("first_cnt", 64'(c32), 64'd1);

    rand_in();
    mdata = {$urandom, 32'h8081F2F3};
    sel = 0; alu = 64'h1002;
    tick();
    chk("alu_mode", 64'(d32), 64'h1002);

    sel = 1; size = 2'b00; uns = 0; alu = 64'h1;
    tick();
    chk("byte_s", 64'(d32), 64'hFFFFFFF2);
    uns = 1;
    tick();
    chk("byte_u", 64'(d32), 64'hF2);
    uns = 0; size = 2'b01; alu = 64'h2;
    tick();
    chk("half_s", 64'(d32), 64'hFFFF8081);

    mem_valid = 1; swr = 1; addr = 5'd5; alu = 64'h1;
    tick();
    chk("mis_flag", 64'(m32), 64'd1);
    chk("mis_we", 64'(we32), 64'd0);
    sel = 0; addr = 5'd0;
    tick();
    chk("x0_we", 64'(we32), 64'd0);

    repeat (4) begin
      rand_in();
      mem_stall = 1'b1;
      tick();
    end
    mem_flush = 1'b1;
    tick();
    chk("bubble_v", 64'(v32), 64'd0);
    chk("bubble_d", d64, 64'd0);

    repeat (300) begin
      rand_in();
      mem_stall = ($urandom_range(0, 7) == 0);
      mem_flush = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0) alu[2:0] = 3'b000;
      tick();
    end

    rand_in();
    mem_stall = 1'b1;
    #2 reset = 1'b1;
    model_clear(1'b0);
    #1 check_all();
    #1 reset = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      rand_in();
      mem_valid = 1'b1;
      tick();
      chk("wrap_cnt", 64'(c32), 64'(i % 16));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
